gray_rx_decoder: RTL and testbench
==================================

Name: gray_rx_decoder

Overview:
- Downstream consumer of the 4-bit binary-to-Gray encoder stage.
- Accepts a Gray-coded word that may come from an unrelated clock domain and passes it through a parameterised synchroniser.
- Converts the synchronised word back to natural binary and reports each change as a one-cycle update with count direction.
- Flags any step where more than one Gray bit changed, since that indicates a CDC or encoding fault, and keeps an error count.

Parameters:
- WIDTH, 4: Gray/binary word width in bits (minimum 2).
- SYNC_STAGES, 2: number of synchroniser flops on gray_in (minimum 2).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1: clock; all logic on the rising edge.
- rst  in  1: synchronous, active-low reset.
- gray_in  in  WIDTH: Gray word; may be asynchronous to clk.
- err_clr  in  1: synchronous clear of err_sticky and err_cnt.
- bin_data  out  WIDTH: last accepted value, in natural binary.
- bin_valid  out  1: one-cycle pulse when bin_data updates.
- dir_up  out  1: valid with bin_valid. 1 = new value equals old+1 mod 2^WIDTH; 0 = any other change.
- multi_err  out  1: one-cycle pulse, coincident with bin_valid, when ≥2 bits changed.
- err_sticky  out  1: set by multi_err, held until err_clr.
- err_cnt  out  ERR_CNT_W: count of multi-bit events, saturating.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All synchroniser flops, prev_gray, bin_data, bin_valid, dir_up, multi_err, err_sticky and err_cnt go to 0.
  - Reset mid-operation discards any in-flight sample; no pulse is emitted for it.
- Synchroniser:
  - gray_in feeds a SYNC_STAGES-deep shift chain; g_s is the last stage.
  - No logic between stages.
- Change detection (each cycle):
  - diff = g_s XOR prev_gray, and n = popcount(diff).
  - prev_gray <= g_s every cycle.
- n = 0:
  - bin_valid, multi_err and dir_up are driven 0.
  - bin_data holds.
- n = 1:
  - bin_data <= gray2bin(g_s), bin_valid <= 1, multi_err <= 0.
  - dir_up <= 1 when gray2bin(g_s) == bin_data + 1 mod 2^WIDTH, else 0.
  - Wrap-around: Gray 1000 (15) to 0000 (0) gives dir_up=1; 0000 to 1000 gives dir_up=0.
- n ≥ 2:
  - bin_data <= gray2bin(g_s), bin_valid <= 1, multi_err <= 1, dir_up <= 0.
  - err_sticky <= 1.
  - err_cnt increments, saturating at 2^ERR_CNT_W-1.
- gray2bin: b[W-1] = g[W-1]; b[i] = b[i+1] XOR g[i].
- Latency: a stable change on gray_in appears on bin_data/bin_valid after SYNC_STAGES+1 clk edges.
- err_clr:
  - err_clr=1 alone: err_sticky <= 0, err_cnt <= 0.
  - err_clr in the same cycle as a multi-bit event: the event wins. err_sticky = 1, err_cnt = 1.
- First sample after reset is compared against prev_gray=0, so a nonzero static input yields one update pulse.
  - Example: gray_in held at 0011 from reset gives bin_data=2, bin_valid=1, dir_up=0, multi_err=1.
- Outputs are registered only; no combinational path from any input to any output.

Decomposition:
- Package gray_pkg:
  - Default WIDTH constant.
  - Functions gray2bin(WIDTH) and popcount(WIDTH).
  - The same package is shared by the existing encoder for bin2gray.
- Sub-module gray_sync_chain (WIDTH, SYNC_STAGES): plain flop chain with synchronous active-low reset. It is reused by other CDC paths.
- Top level holds the change detector, direction compare and error logic.

Test Plan:
- Reset then step gray_in 0000→0001→0011→0010, each held 4 cycles. Expect bin_data 1, 2, 3, each with a one-cycle bin_valid and dir_up=1; multi_err=0; each update 3 edges after the input change.
- Count down from Gray 0011 to 0001 to 0000. Expect bin_data 1 then 0, bin_valid pulses, dir_up=0, no error.
- Wrap: drive 1000 (bin 15), then 0000. Expect bin_data=0, dir_up=1, multi_err=0. Then 0000→1000: bin_data=15, dir_up=0.
- Multi-bit jump from 0001 to 0110. Expect bin_data=4, bin_valid=1, multi_err=1, err_sticky=1, err_cnt=1. Repeat 300 multi-bit jumps: err_cnt saturates at 255.
- err_clr asserted in the same cycle as a multi-bit event, with err_cnt=5 beforehand. Expect err_sticky=1, err_cnt=1. err_clr alone a cycle later gives err_sticky=0, err_cnt=0.
- Change gray_in and assert rst=0 one cycle later, before the update reaches bin_data. Expect all outputs 0 and no bin_valid pulse. After rst release with gray_in=0000, outputs stay quiet.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by both the encoder and receive-side decoder.
// Functions work at a fixed 32-bit width; callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_W     = 4;
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros decode to zeros, so zero-extended narrow words convert correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [5:0] popcount(input logic [GRAY_MAX_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Plain multi-flop synchroniser for a bus arriving from another clock domain.
// No logic between stages; synchronous active-low reset.
module gray_sync_chain
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Receive side of the Gray link: synchronise, decode to binary, report each
// change with direction, and flag/count steps where more than one bit moved.
module gray_rx_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_W,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     bin_data,
    output logic                 bin_valid,
    output logic                 dir_up,
    output logic                 multi_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
    localparam logic [WIDTH-1:0]     ONE_W   = WIDTH'(1);

    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] bin_inc;
    logic [5:0]       n_bits;
    logic             changed;
    logic             multi_event;
    logic             step_up;

    gray_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_in),
        .q   (g_s)
    );

    always_comb begin
        diff        = g_s ^ prev_gray;
        n_bits      = popcount(GRAY_MAX_W'(diff));
        bin_next    = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
        bin_inc     = bin_data + ONE_W;
        changed     = (n_bits != 6'd0);
        multi_event = (n_bits > 6'd1);
        step_up     = (n_bits == 6'd1) && (bin_next == bin_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_gray <= '0;
            bin_data  <= '0;
            bin_valid <= 1'b0;
            dir_up    <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            prev_gray <= g_s;
            bin_valid <= changed;
            dir_up    <= step_up;
            multi_err <= multi_event;
            if (changed) begin
                bin_data <= bin_next;
            end
        end
    end

    // A multi-bit event in the same cycle as err_clr wins: counter restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (multi_event) begin
            err_sticky <= 1'b1;
            if (err_clr) begin
                err_cnt <= ERR_CNT_W'(1);
            end else if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder: expected updates are queued when gray_in
// is driven and checked (value, direction, error flag, arrival cycle) on each pulse.
module tb_gray_rx_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] bin_data;
    logic       bin_valid;
    logic       dir_up;
    logic       multi_err;
    logic       err_sticky;
    logic [7:0] err_cnt;

    typedef struct {
        logic [3:0] bin;
        logic       dir;
        logic       multi;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [3:0] m_gray;
    logic [3:0] m_bin;

    gray_rx_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .ERR_CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .bin_data   (bin_data),
        .bin_valid  (bin_valid),
        .dir_up     (dir_up),
        .multi_err  (multi_err),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference decode written as a prefix XOR of shifts.
    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic expect_change(input logic [3:0] g);
        exp_t e;
        int   n;
        n = $countones(g ^ m_gray);
        if (n != 0) begin
            e.bin   = ref_bin(g);
            e.dir   = (n == 1) && (ref_bin(g) == 4'(m_bin + 4'd1));
            e.multi = (n >= 2);
            e.cyc   = cyc + 3;
            sb.push_back(e);
            m_bin = e.bin;
        end
        m_gray = g;
    endtask

    task automatic step(input logic [3:0] g, input int hold);
        gray_in = g;
        expect_change(g);
        repeat (hold) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin_data"},   32'(bin_data),   0);
        chk({tag, "_bin_valid"},  32'(bin_valid),  0);
        chk({tag, "_dir_up"},     32'(dir_up),     0);
        chk({tag, "_multi_err"},  32'(multi_err),  0);
        chk({tag, "_err_sticky"}, 32'(err_sticky), 0);
        chk({tag, "_err_cnt"},    32'(err_cnt),    0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bin_valid) begin
            chk("pulse_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("bin_data",  32'(bin_data),  32'(e.bin));
                chk("dir_up",    32'(dir_up),    32'(e.dir));
                chk("multi_err", 32'(multi_err), 32'(e.multi));
                chk("latency",   32'(cyc),       32'(e.cyc));
            end
        end else begin
            if (multi_err) chk("multi_without_valid", 32'(multi_err), 0);
        end
    end

    initial begin
        rst     = 1'b0;
        gray_in = 4'b0000;
        err_clr = 1'b0;
        m_gray  = 4'b0000;
        m_bin   = 4'b0000;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // counting up
        step(4'b0001, 4);
        step(4'b0011, 4);
        step(4'b0010, 4);
        chk("up_sticky", 32'(err_sticky), 0);

        // counting down
        step(4'b0011, 4);
        step(4'b0001, 4);
        step(4'b0000, 4);

        // wrap in both directions
        step(4'b1000, 4);
        step(4'b0000, 4);
        step(4'b1000, 4);
        step(4'b0000, 4);
        step(4'b0001, 4);
        chk("pre_multi_sticky", 32'(err_sticky), 0);
        chk("pre_multi_cnt",    32'(err_cnt),    0);

        // single multi-bit jump 0001 -> 0110
        step(4'b0110, 4);
        chk("multi_sticky", 32'(err_sticky), 1);
        chk("multi_cnt",    32'(err_cnt),    1);

        // 300 more multi-bit jumps saturate the counter
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 4'b0001 : 4'b0110, 2);
        end
        repeat (4) @(negedge clk);
        chk("sat_cnt",    32'(err_cnt),    255);
        chk("sat_sticky", 32'(err_sticky), 1);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr_sticky", 32'(err_sticky), 0);
        chk("clr_cnt",    32'(err_cnt),    0);

        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 4'b0001 : 4'b0110, 4);
        end
        chk("five_cnt", 32'(err_cnt), 5);

        // err_clr lands on the same edge as a multi-bit event
        gray_in = 4'b0110;
        expect_change(4'b0110);
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("coinc_sticky", 32'(err_sticky), 1);
        chk("coinc_cnt",    32'(err_cnt),    1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("clr2_sticky", 32'(err_sticky), 0);
        chk("clr2_cnt",    32'(err_cnt),    0);

        // reset while a change is still inside the synchroniser
        gray_in = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("midrst");
        rst    = 1'b1;
        m_gray = 4'b0000;
        m_bin  = 4'b0000;
        repeat (8) @(negedge clk);
        chk_all_zero("post_rst");

        // nonzero static input out of reset yields one update
        rst     = 1'b0;
        gray_in = 4'b0011;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        expect_change(4'b0011);
        repeat (6) @(negedge clk);
        chk("boot_sticky", 32'(err_sticky), 1);
        chk("boot_cnt",    32'(err_cnt),    1);
        chk("boot_bin",    32'(bin_data),   2);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
